// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the display scan controller and its serialiser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

    localparam int BITS_PER_DIGIT = 8;   // dp bit plus segments g..a
    localparam int SETTLE_CYCLES  = 2;   // mux register plus decode settle time
    localparam int MAX_DIGITS     = 6;   // widest frame the select bus may address

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        SHIFT,
        LATCH,
        DONE
    } scan_state_e;

endpackage

// File: rtl/display_scan_controller_serial_shift_out.sv
// Shifts one 8-bit digit word MSB first onto the serial data/clock pair.
// Latency: 16*CLK_DIV cycles from load to the cycle done_o is high (done_o marks the last one).
// Backpressure: none; a load restarts the word, done_o is a one-cycle pulse.
module serial_shift_out
    import display_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic [BITS_PER_DIGIT-1:0] word_i,
    output logic                      ser_data_o,
    output logic                      ser_clk_o,
    output logic                      done_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(BITS_PER_DIGIT);

    logic                      active_q, active_d;
    logic                      phase_q, phase_d;     // 0 = serial clock low half, 1 = high half
    logic [DIV_W-1:0]          div_q, div_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [BITS_PER_DIGIT-1:0] sr_q, sr_d;
    logic                      half_end;

    assign half_end   = (div_q == DIV_W'(CLK_DIV - 1));
    assign done_o     = active_q & phase_q & half_end & (bit_q == BIT_W'(BITS_PER_DIGIT - 1));
    // Data only moves on the edge that drops the clock, so it is stable across the rising edge.
    assign ser_data_o = active_q & sr_q[BITS_PER_DIGIT-1];
    assign ser_clk_o  = active_q & phase_q;

    // Next-state: half-period divider, clock phase, bit count and shift register.
    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        if (load_i) begin
            active_d = 1'b1;
            phase_d  = 1'b0;
            div_d    = '0;
            bit_d    = '0;
            sr_d     = word_i;
        end else if (active_q) begin
            if (half_end) begin
                div_d = '0;
                if (phase_q) begin
                    phase_d = 1'b0;
                    sr_d    = {sr_q[BITS_PER_DIGIT-2:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                    if (done_o) begin
                        active_d = 1'b0;
                    end
                end else begin
                    phase_d = 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Steps the digit mux, captures each digit's dp+segments and serialises a frame to the display chain.
// Latency: refresh to o_frame_done = 1 + NUM_DIGITS*(3 + 16*CLK_DIV) + CLK_DIV cycles.
// Backpressure: refresh strobes while busy (including the DONE cycle) are dropped, not queued.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_refresh,
    input  logic                  i_en,
    input  logic [NUM_DIGITS-1:0] i_dp_mask,
    input  logic [6:0]            i_segments,
    output logic [2:0]            o_segment_select,
    output logic                  o_mux_en,
    output logic                  o_ser_data,
    output logic                  o_ser_clk,
    output logic                  o_ser_latch,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int         CNT_MAX    = (CLK_DIV > SETTLE_CYCLES) ? CLK_DIV : SETTLE_CYCLES;
    localparam int         CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    scan_state_e               state_q, state_d;
    logic [2:0]                digit_q, digit_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;      // shared by SETTLE and LATCH dwell timing
    logic                      en_q, en_d;
    logic                      shift_load;
    logic                      shift_done;
    logic [MAX_DIGITS-1:0]     dp_mask_ext;
    logic [BITS_PER_DIGIT-1:0] shift_word;

    // Widen the mask so the 3-bit digit index is always in range, whatever NUM_DIGITS is.
    assign dp_mask_ext = MAX_DIGITS'(i_dp_mask);
    assign shift_word  = {dp_mask_ext[digit_q] & en_q, i_segments};

    assign o_segment_select = digit_q;
    assign o_busy           = (state_q != IDLE);
    assign o_mux_en         = en_q & o_busy;
    assign o_ser_latch      = (state_q == LATCH);
    assign o_frame_done     = (state_q == DONE);

    serial_shift_out #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk_i      (i_clk),
        .rst_i      (i_reset),
        .load_i     (shift_load),
        .word_i     (shift_word),
        .ser_data_o (o_ser_data),
        .ser_clk_o  (o_ser_clk),
        .done_o     (shift_done)
    );

    // Frame sequencer: next state, digit/dwell counters, enable capture and shifter load.
    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        cnt_d      = cnt_q;
        en_d       = en_q;
        shift_load = 1'b0;
        case (state_q)
            IDLE: begin
                digit_d = '0;
                cnt_d   = '0;
                if (i_refresh) begin
                    en_d    = i_en;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    shift_load = 1'b1;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (shift_done) begin
                    if (digit_q == LAST_DIGIT) begin
                        cnt_d   = '0;
                        state_d = LATCH;
                    end else begin
                        digit_d = digit_q + 1'b1;
                        state_d = SELECT;
                    end
                end
            end
            LATCH: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                digit_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any frame in flight without latching.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            digit_q <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: default-parameter instance with random frames, plus a NUM_DIGITS=4/CLK_DIV=1 instance.
// Latency: expected frame-done cycle is computed from the refresh cycle.
// Backpressure: the reference model drops refreshes that arrive while a frame is outstanding.
module tb_display_scan_controller;

    localparam int NA    = 6;
    localparam int CA    = 2;
    localparam int PA    = 3 + 16 * CA;
    localparam int LEN_A = 1 + NA * PA + CA;
    localparam int NB    = 4;
    localparam int CB    = 1;
    localparam int LEN_B = 1 + NB * (3 + 16 * CB) + CB;

    typedef struct {
        int          done_cyc;
        logic [47:0] bits;
        logic        en;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- instance A (defaults) ----------------
    logic        rst_a, ref_a, en_a;
    logic [5:0]  dpm_a;
    logic [6:0]  seg_a = 7'h0;
    logic [2:0]  sel_a;
    logic        mux_a, sd_a, sc_a, sl_a, busy_a, fd_a;
    int          dig_a [6];

    display_scan_controller u_dut_a (
        .i_clk (clk), .i_reset (rst_a), .i_refresh (ref_a), .i_en (en_a),
        .i_dp_mask (dpm_a), .i_segments (seg_a), .o_segment_select (sel_a),
        .o_mux_en (mux_a), .o_ser_data (sd_a), .o_ser_clk (sc_a),
        .o_ser_latch (sl_a), .o_busy (busy_a), .o_frame_done (fd_a)
    );

    // ---------------- instance B (4 digits, CLK_DIV=1) ----------------
    logic        rst_b, ref_b;
    logic [6:0]  seg_b = 7'h0;
    logic [2:0]  sel_b;
    logic        mux_b, sd_b, sc_b, sl_b, busy_b, fd_b;

    display_scan_controller #(.NUM_DIGITS (NB), .CLK_DIV (CB)) u_dut_b (
        .i_clk (clk), .i_reset (rst_b), .i_refresh (ref_b), .i_en (1'b1),
        .i_dp_mask (4'b1010), .i_segments (seg_b), .o_segment_select (sel_b),
        .o_mux_en (mux_b), .o_ser_data (sd_b), .o_ser_clk (sc_b),
        .o_ser_latch (sl_b), .o_busy (busy_b), .o_frame_done (fd_b)
    );

    function automatic logic [6:0] seg7(input int v);
        case (v)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
            8: return 7'h7F; 9: return 7'h6F; default: return 7'h00;
        endcase
    endfunction

    // Whole-frame reference: digit 0 first, each byte dp then g..a, dp gated by enable, blank when disabled.
    function automatic logic [47:0] frame_bits(input int d[6], input logic [5:0] dpm, input logic en);
        logic [47:0] b;
        logic [7:0]  w;
        b = '0;
        for (int k = 0; k < 6; k++) begin
            w = {dpm[k] & en, en ? seg7(d[k]) : 7'h00};
            b[47 - 8 * k -: 8] = w;
        end
        return b;
    endfunction

    // Registered BCD mux models: one cycle from select to segments, blank when not enabled.
    always @(posedge clk) seg_a <= mux_a ? seg7((sel_a < 3'd6) ? dig_a[sel_a] : 15) : 7'h00;
    always @(posedge clk) seg_b <= mux_b ? seg7(int'(sel_b)) : 7'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    frame_t exp_q[$];
    int     busy_until_a = -1;

    task automatic pulse_a(input int expd[6]);
        frame_t f;
        ref_a = 1'b1;
        if (cyc > busy_until_a) begin
            f.done_cyc   = cyc + LEN_A;
            f.bits       = frame_bits(expd, dpm_a, en_a);
            f.en         = en_a;
            exp_q.push_back(f);
            busy_until_a = cyc + LEN_A;
        end
        @(posedge clk);
        #1;
        ref_a = 1'b0;
    endtask

    task automatic check_idle_a(input string name);
        check(name, {sel_a, mux_a, sd_a, sc_a, sl_a, busy_a, fd_a}, 64'h0);
    endtask

    // ---------------- monitor A ----------------
    logic [47:0] cap_a;
    int          nb_a, lat_a, stray_a = 0;
    logic        sel_ok_a, mux_ok_a, tim_ok_a, prev_sc_a, prev_sd_a;
    frame_t      e_a;

    always @(negedge clk) begin
        if (rst_a) begin
            cap_a = '0; nb_a = 0; lat_a = 0;
            sel_ok_a = 1'b1; mux_ok_a = 1'b1; tim_ok_a = 1'b1;
            prev_sc_a = 1'b0; prev_sd_a = 1'b0;
        end else begin
            if (sel_a > 3'(NA - 1)) sel_ok_a = 1'b0;
            if (busy_a && exp_q.size() > 0 && mux_a !== exp_q[0].en) mux_ok_a = 1'b0;
            if (sc_a && sd_a !== prev_sd_a) tim_ok_a = 1'b0;
            if (sc_a && !prev_sc_a) begin
                cap_a = {cap_a[46:0], sd_a};
                nb_a++;
                if (int'(sel_a) != (nb_a - 1) / 8) sel_ok_a = 1'b0;
            end
            if (sl_a) begin
                lat_a++;
                if (sc_a) tim_ok_a = 1'b0;
                if (exp_q.size() == 0) stray_a++;
            end
            if (fd_a) begin
                check("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_a = exp_q.pop_front();
                    check("done_cycle", cyc, e_a.done_cyc);
                    check("frame_bits", cap_a, e_a.bits);
                    check("bit_count", nb_a, 48);
                    check("latch_len", lat_a, CA);
                    check("select_seq", sel_ok_a, 1);
                    check("mux_en_hold", mux_ok_a, 1);
                    check("ser_timing", tim_ok_a, 1);
                    check("done_ser_data", sd_a, 0);
                    check("done_busy", busy_a, 1);
                end
                cap_a = '0; nb_a = 0; lat_a = 0;
                sel_ok_a = 1'b1; mux_ok_a = 1'b1; tim_ok_a = 1'b1;
            end
            prev_sc_a = sc_a;
            prev_sd_a = sd_a;
        end
    end

    // ---------------- monitor B ----------------
    int   expb_q[$];
    int   nb_b, lat_b, last_rise_b, exp_c;
    logic sel_ok_b, per_ok_b, prev_sc_b;
    logic b_done = 1'b0;

    always @(negedge clk) begin
        if (rst_b) begin
            nb_b = 0; lat_b = 0; last_rise_b = 0;
            sel_ok_b = 1'b1; per_ok_b = 1'b1; prev_sc_b = 1'b0;
        end else begin
            if (sel_b > 3'(NB - 1)) sel_ok_b = 1'b0;
            if (sc_b && prev_sc_b) per_ok_b = 1'b0;
            if (sc_b && !prev_sc_b) begin
                if (nb_b % 8 != 0 && cyc - last_rise_b != 2) per_ok_b = 1'b0;
                last_rise_b = cyc;
                nb_b++;
            end
            if (sl_b) lat_b++;
            if (fd_b) begin
                check("b_done_expected", expb_q.size() > 0, 1);
                if (expb_q.size() > 0) begin
                    exp_c = expb_q.pop_front();
                    check("b_frame_len", cyc, exp_c);
                    check("b_select_max", sel_ok_b, 1);
                    check("b_ser_period", per_ok_b, 1);
                    check("b_bit_count", nb_b, 32);
                    check("b_latch_len", lat_b, CB);
                    check("b_done_busy", busy_b, 1);
                end
                nb_b = 0; lat_b = 0; sel_ok_b = 1'b1; per_ok_b = 1'b1;
            end
            prev_sc_b = sc_b;
        end
    end

    // ---------------- stimulus B ----------------
    initial begin
        rst_b = 1'b1;
        ref_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        for (int f = 0; f < 3; f++) begin
            goto_cycle(cyc + 5);
            ref_b = 1'b1;
            expb_q.push_back(cyc + LEN_B);
            @(posedge clk);
            #1;
            ref_b = 1'b0;
            goto_cycle(cyc + LEN_B);
        end
        b_done = 1'b1;
    end

    // ---------------- stimulus A + summary ----------------
    initial begin
        int s;
        int expd [6];
        rst_a = 1'b1; ref_a = 1'b0; en_a = 1'b0; dpm_a = '0;
        for (int k = 0; k < 6; k++) dig_a[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_a("reset_outputs");
        rst_a = 1'b0;
        goto_cycle(cyc + 4);

        // Basic frame with known digits.
        dig_a = '{3, 4, 5, 9, 1, 2};
        dpm_a = 6'b010100;
        en_a  = 1'b1;
        pulse_a(dig_a);
        goto_cycle(cyc + LEN_A + 5);

        // Refreshes during busy and in the DONE cycle are dropped; one after DONE starts a frame.
        for (int k = 0; k < 6; k++) dig_a[k] = $urandom_range(0, 9);
        s = cyc;
        pulse_a(dig_a);
        goto_cycle(s + 50);
        pulse_a(dig_a);
        goto_cycle(s + 212);
        pulse_a(dig_a);
        pulse_a(dig_a);
        for (int k = 0; k < 6; k++) dig_a[k] = $urandom_range(0, 9);
        pulse_a(dig_a);
        goto_cycle(cyc + LEN_A + 5);

        // Settle window: change during first SETTLE cycle is captured, change after capture is not.
        for (int k = 0; k < 6; k++) dig_a[k] = $urandom_range(0, 9);
        expd    = dig_a;
        expd[1] = (dig_a[1] + 1 + $urandom_range(0, 7)) % 10;
        s = cyc;
        pulse_a(expd);
        goto_cycle(s + 2 + PA);
        dig_a[1] = expd[1];
        goto_cycle(s + 4 + 2 * PA);
        dig_a[2] = (dig_a[2] + 1 + $urandom_range(0, 7)) % 10;
        goto_cycle(s + LEN_A + 5);

        // Disabled frame: blank segments, dp forced off, latch still pulses; late enable has no effect.
        en_a  = 1'b0;
        dpm_a = 6'h3F;
        s = cyc;
        pulse_a(dig_a);
        goto_cycle(s + 60);
        en_a = 1'b1;
        goto_cycle(s + LEN_A + 5);

        // Reset during the shift of digit 2 aborts the frame without a latch pulse.
        dpm_a = 6'($urandom);
        s = cyc;
        pulse_a(dig_a);
        goto_cycle(s + 1 + 2 * PA + 8);
        rst_a = 1'b1;
        exp_q.delete();
        busy_until_a = -1;
        @(posedge clk);
        #1;
        check_idle_a("reset_abort");
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        goto_cycle(cyc + 250);

        // Random traffic: random gaps, enable toggles at any time, new digits only between frames.
        for (int it = 0; it < 10; it++) begin
            goto_cycle(cyc + $urandom_range(1, 240));
            en_a = ($urandom_range(0, 4) != 0);
            if (cyc > busy_until_a) begin
                for (int k = 0; k < 6; k++) dig_a[k] = $urandom_range(0, 9);
                dpm_a = 6'($urandom);
            end
            pulse_a(dig_a);
        end

        for (int i = 0; i < 1000 && exp_q.size() > 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        check("stray_latch", stray_a, 0);
        for (int i = 0; i < 2000 && !b_done; i++) @(posedge clk);
        check("b_complete", b_done, 1);
        check("b_drain", expb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
